a2d_spi_model: RTL
==================

// Module: a2d_spi_model
// PURPOSE
//  Parametrised behavioural-but-synthesisable SPI slave model of the ADC128S-style A2D on the DE0.
//  Sits in the Segway bench between the DUT A2D_* pins and stimulus. It serves ld_cell_lft, ld_cell_rght, battery, etc.
//  Generalises the fixed 8-ch/12-bit part: channel count, result width, per-channel ramp mode, frame-error and conversion telemetry.
//  Pipelined like the real part: the channel addressed in frame N is returned in frame N+1.
// PARAMETERS
//  NUM_CH     8    channels served, 1..8; address field is always 3 bits.
//  DATA_W     12   result width, 8..12; right-justified in 16-bit frame, upper bits 0.
//  RAMP_STEP  1    added to a channel's ramp register after each completed conversion of that channel.
//  RAMP_INIT  0    reset value of every ramp register.
// PORTS
//  clk        in   1                 system clock; also oversamples SPI pins.
//  rst_n      in   1                 async active-low reset.
//  SS_n       in   1                 SPI select from DUT, active low.
//  SCLK       in   1                 SPI clock from DUT, mode 0.
//  MOSI       in   1                 command bits from DUT.
//  MISO       out  1                 result bits; 1'bz while SS_n high.
//  ch_vals    in   NUM_CH*DATA_W     channel k value = ch_vals[k*DATA_W +: DATA_W] when ramp_en=0.
//  ramp_en    in   1                 1: return internal ramp[k] instead of ch_vals.
//  last_ch    out  3                 channel latched from the most recent good frame.
//  conv_cnt   out  16                good frames completed; wraps 0xFFFF->0.
//  frame_err  out  1                 sticky; set on a short/long frame, cleared only by reset.
//  busy       out  1                 high while a frame is in progress (state != IDLE).
// BEHAVIOUR
//  Reset: MISO=z, last_ch=0, conv_cnt=0, frame_err=0, busy=0, ramp[*]=RAMP_INIT, bit_cnt=0, state IDLE.
//  Input sync: SS_n, SCLK, MOSI pass through a 3-flop synchroniser each, aligned. Edges are detected on flops 2/3.
//  Detection latency is 3 clk. Legal SCLK half-period >= 4 clk and SS_n setup >= 4 clk.
//  FSM IDLE -> SHIFT on SS_n fall:
//   tx_shft <= {4'b0, zero-extend(val[last_ch]) to 12 bits}. val = ramp_en ? ramp[last_ch] : ch_vals slice.
//   MISO drives tx_shft[15] within 1 clk of detected fall.
//  SHIFT:
//   - each detected SCLK rise: rx_shft <= {rx_shft[14:0],MOSI_sync}; bit_cnt++.
//   - each detected SCLK fall after the first rise: tx_shft <<= 1.
//  SHIFT -> IDLE on SS_n rise; MISO returns to z.
//   - bit_cnt==16 (good frame):
//     - nxt = rx_shft[13:11]. last_ch <= (nxt >= NUM_CH) ? 0 : nxt.
//     - conv_cnt++.
//     - if ramp_en: ramp[served channel] += RAMP_STEP, wrapping mod 2^DATA_W.
//     - All updates occur in the same clk.
//   - bit_cnt!=16: frame_err<=1. last_ch, conv_cnt and ramps are unchanged.
//  bit_cnt saturates at 31. Extra SCLK rises make the frame bad, not wrapped.
//  SCLK edges while in IDLE are ignored. An SS_n fall while in SHIFT is impossible after sync and needs no handling.
//  Simultaneous SS_n rise and SCLK rise in the same sync clk: the SCLK rise counts first, then the frame closes.
//  ch_vals are sampled only at SS_n fall. Changes mid-frame do not affect the frame in flight.
//  Async reset mid-frame aborts immediately. The next frame after reset returns channel 0.
// STRUCTURE
//  Package a2d_model_pkg:
//   - FRAME_W=16, ADDR_MSB=13, ADDR_LSB=11, PAD_W=4.
//   - typedef enum logic {IDLE,SHIFT} a2d_state_t.
//  Sub-module spi_edge_sync: 3-flop sync plus rise/fall pulses, one instance per pin (edge pulses unused for MOSI).
//  Top holds the FSM, shifters, bit counter, ramp array and telemetry.
// TESTING
//  1 Reset, ch_vals ch0=0xABC, ch1=0x123; frame cmd ch1 -> MISO 0x0ABC, last_ch=1, conv_cnt=1; next frame -> 0x0123.
//  2 DATA_W=10, NUM_CH=4: ch3=0x3FF, frames addr 3 then addr 6 -> 0x03FF returned; addr 6 -> last_ch=0.
//  3 ramp_en=1, RAMP_INIT=0xFFE, step 1; 3 frames on ch0 -> 0x0FFE, 0x0FFF, 0x0000 (wrap).
//  4 SS_n raised after 9 SCLK -> frame_err=1, last_ch/conv_cnt unchanged; next good frame returns the prior channel.
//  5 rst_n pulsed low at bit 7 -> MISO=z, busy=0, conv_cnt=0 immediately; next frame returns ch0.
//  6 Full Segway bench: DUT round-robin reads ch0/4/5 -> values and conv_cnt match the scoreboard, frame_err=0.

Source files
------------

// File: rtl/a2d_spi_model_pkg.sv
// Shared frame geometry and FSM state type for the A2D SPI slave model.
// Pure definitions: no timing, no flow control.
package a2d_model_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_MSB = 13;
  localparam int ADDR_LSB = 11;
  localparam int PAD_W    = 4;
  localparam int RES_W    = FRAME_W - PAD_W;
  localparam int CNT_W    = 5;

  localparam logic [CNT_W-1:0] GOOD_BITS = CNT_W'(FRAME_W);

  typedef enum logic {IDLE, SHIFT} a2d_state_t;

  // Bit counter stops at all-ones so an over-long frame cannot alias back to 16.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/a2d_spi_model_if.sv
// SPI pin bundle between a bus master (DUT) and the A2D slave model.
// Wires only: no latency, no flow control beyond SS_n framing.
interface a2d_spi_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  wire  MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_model_spi_edge_sync.sv
// Three-flop synchroniser for one SPI pin with single-clk rise/fall pulses.
// Level appears 2 clk after the pin, edge pulses act on the 3rd clk; no backpressure.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {3{RST_VAL}};
    else        sr <= {sr[1:0], pin};
  end

  // Level and edges all come from flops 2/3 so data and strobes stay aligned.
  assign sync = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/a2d_spi_model.sv
// ADC128S-style SPI slave model: address in frame N selects the result returned in frame N+1.
// Pins are oversampled with 3 clk detection latency; the master paces everything, no backpressure.
module a2d_spi_model
  import a2d_model_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 12,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_INIT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  a2d_spi_model_if.slave           spi,
  input  logic [NUM_CH*DATA_W-1:0] ch_vals,
  input  logic                     ramp_en,
  output logic [2:0]               last_ch,
  output logic [15:0]              conv_cnt,
  output logic                     frame_err,
  output logic                     busy
);

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  logic ss_lvl_unused, sclk_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .pin(spi.SS_n),
    .sync(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(spi.SCLK),
    .sync(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin(spi.MOSI),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  a2d_state_t         state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic [2:0]         last_d, nxt;
  logic [15:0]        conv_d;
  logic               err_d;
  logic [DATA_W-1:0]  ramp_q [NUM_CH];
  logic [DATA_W-1:0]  ramp_d [NUM_CH];
  logic [DATA_W-1:0]  sel_val;
  logic [RES_W-1:0]   sel12;
  logic               rx_msb_unused;

  assign rx_msb_unused = rx_q[FRAME_W-1];

  // Result for the channel addressed by the previous good frame.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (last_ch == 3'(k)) sel_val = ramp_en ? ramp_q[k] : ch_vals[k*DATA_W +: DATA_W];
    end
    sel12 = '0;
    sel12[DATA_W-1:0] = sel_val;
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    last_d  = last_ch;
    conv_d  = conv_cnt;
    err_d   = frame_err;
    ramp_d  = ramp_q;
    nxt     = '0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          tx_d    = {{PAD_W{1'b0}}, sel12};
          rx_d    = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_d   = {rx_q[FRAME_W-2:0], mosi_s};
          cnt_d  = sat_inc(cnt_q);
          seen_d = 1'b1;
        end
        // Mode 0: the fall before the first rise must not shift out bit 15 early.
        if (sclk_fall && seen_q) tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        // Closing uses the *_d values so a rise in the same clk still counts.
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_d == GOOD_BITS) begin
            nxt    = rx_d[ADDR_MSB:ADDR_LSB];
            last_d = ({29'd0, nxt} >= 32'(NUM_CH)) ? 3'd0 : nxt;
            conv_d = conv_cnt + 16'd1;
            if (ramp_en) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (last_ch == 3'(k)) ramp_d[k] = ramp_q[k] + DATA_W'(RAMP_STEP);
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
      last_ch   <= '0;
      conv_cnt  <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) ramp_q[k] <= DATA_W'(RAMP_INIT);
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      last_ch   <= last_d;
      conv_cnt  <= conv_d;
      frame_err <= err_d;
      for (int k = 0; k < NUM_CH; k++) ramp_q[k] <= ramp_d[k];
    end
  end

  assign spi.MISO = (state_q == SHIFT) ? tx_q[FRAME_W-1] : 1'bz;
  assign busy     = (state_q != IDLE);

endmodule
